sdram_bus_arbiter: RTL and testbench

//  Two-master arbiter sharing the single SDRAM controller port between the CPU memory bus (m0)
//  and a second requester such as DMA or video fetch (m1). Both sides use valid/ready handshakes

---
 rtl/sdram_bus_arbiter.sv | 119 +++++++++++
 tb/tb_sdram_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bus_arbiter.sv
// Two-master arbiter in front of one SDRAM controller port.
// Registered request, one-cycle ready pulse, watchdog timeout.
module sdram_bus_arbiter #(
  parameter int          ADDR_W     = 24,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int          TIMEOUT    = 1023,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_wstrb,
  input  logic [31:0]       m0_wdata,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_wstrb,
  input  logic [31:0]       m1_wdata,
  output logic [31:0]       m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [3:0]        s_wstrb,
  output logic [31:0]       s_wdata,
  input  logic [31:0]       s_rdata,
  output logic [1:0]        grant,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          last;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          pick1;
  logic          tmo;

  // last holds the index of the current/most recent owner
  assign any_req = m0_valid | m1_valid;
  assign pick1   = m1_valid &
                   (~m0_valid | (~FIXED_PRIO & ~last));
  assign tmo     = (cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: request -> wait for controller/watchdog -> ready pulse
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req)       state_nx = BUSY;
      BUSY:    if (s_ready | tmo) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state and owner
  always_comb begin
    s_valid  = (state == BUSY);
    m0_ready = (state == RESP) & ~last;
    m1_ready = (state == RESP) &  last;
    grant    = 2'b00;
    if (state != IDLE) grant = last ? 2'b10 : 2'b01;
  end

  // Request latch, response capture, watchdog counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= 1'b1;
      s_addr   <= '0;
      s_wstrb  <= '0;
      s_wdata  <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            last    <= pick1;
            s_addr  <= pick1 ? m1_addr  : m0_addr;
            s_wstrb <= pick1 ? m1_wstrb : m0_wstrb;
            s_wdata <= pick1 ? m1_wdata : m0_wdata;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (s_ready) begin
            if (last) m1_rdata <= s_rdata;
            else      m0_rdata <= s_rdata;
          end else if (tmo) begin
            if (last) m1_rdata <= ERR_RDATA;
            else      m0_rdata <= ERR_RDATA;
            err <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed bench: instance A round-robin/TIMEOUT=16,
// instance B fixed-priority/TIMEOUT=8.
module tb_sdram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_valid = 0, m1_valid = 0;
  logic [23:0] m0_addr = 0, m1_addr = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [31:0] s_rdata = 0;
  logic        s_ready_a = 0, s_ready_b = 0;

  logic        a_m0_ready, a_m1_ready, a_s_valid, a_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_wdata;
  logic [23:0] a_s_addr;
  logic [3:0]  a_s_wstrb;
  logic [1:0]  a_grant;

  logic        b_m0_ready, b_m1_ready, b_s_valid, b_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
  logic [23:0] b_s_addr;
  logic [3:0]  b_s_wstrb;
  logic [1:0]  b_grant;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sdram_bus_arbiter #(.ADDR_W(24), .FIXED_PRIO(1'b0), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata),
    .s_valid(a_s_valid), .s_ready(s_ready_a), .s_addr(a_s_addr),
    .s_wstrb(a_s_wstrb), .s_wdata(a_s_wdata), .s_rdata(s_rdata),
    .grant(a_grant), .err(a_err)
  );

  sdram_bus_arbiter #(.ADDR_W(24), .FIXED_PRIO(1'b1), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata),
    .s_valid(b_s_valid), .s_ready(s_ready_b), .s_addr(b_s_addr),
    .s_wstrb(b_s_wstrb), .s_wdata(b_s_wdata), .s_rdata(s_rdata),
    .grant(b_grant), .err(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_valid = 0; m1_valid = 0;
    s_ready_a = 0; s_ready_b = 0;
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({a_s_valid, a_grant, a_err, a_m0_ready, a_m1_ready} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {a_s_valid, a_grant, a_err, a_m0_ready, a_m1_ready});
    end
    nvec++;
    if ({a_s_addr, a_s_wstrb, a_s_wdata, a_m0_rdata} !== 92'b0) begin
      nerr++;
      $display("FAIL reset_data got %h exp 0",
               {a_s_addr, a_s_wstrb, a_s_wdata, a_m0_rdata});
    end
    nvec++;
    if ({b_s_valid, b_grant, b_err} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_b got %b exp 0000", {b_s_valid, b_grant, b_err});
    end
  endtask

  task automatic test_read();
    do_reset();
    m0_valid = 1; m0_addr = 24'h000100; m0_wstrb = 0; m0_wdata = 0;
    step();
    nvec++;
    if ({a_s_valid, a_grant, a_s_wstrb} !== 7'b1_01_0000 ||
        a_s_addr !== 24'h000100) begin
      nerr++;
      $display("FAIL rd_req got v=%b g=%b st=%b a=%h exp 1 01 0000 000100",
               a_s_valid, a_grant, a_s_wstrb, a_s_addr);
    end
    step(); step();
    s_ready_a = 1; s_rdata = 32'h12345678;
    nvec++;
    if (a_m0_ready !== 1'b0) begin
      nerr++;
      $display("FAIL rd_early_ready got %b exp 0", a_m0_ready);
    end
    step();
    s_ready_a = 0; m0_valid = 0;
    nvec++;
    if ({a_m0_ready, a_m1_ready, a_s_valid, a_grant} !== 5'b10_0_01 ||
        a_m0_rdata !== 32'h12345678) begin
      nerr++;
      $display("FAIL rd_resp got r=%b%b v=%b g=%b d=%h exp 10 0 01 12345678",
               a_m0_ready, a_m1_ready, a_s_valid, a_grant, a_m0_rdata);
    end
    step();
    nvec++;
    if ({a_m0_ready, a_grant} !== 3'b0) begin
      nerr++;
      $display("FAIL rd_after got r=%b g=%b exp 0 00", a_m0_ready, a_grant);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    m0_addr = 24'h000010; m1_addr = 24'h000020;
    m0_wstrb = 0; m1_wstrb = 0;
    m0_valid = 1; m1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (a_grant !== exp_g[i] || a_s_valid !== 1'b1 ||
          a_s_addr !== (exp_g[i][1] ? 24'h000020 : 24'h000010)) begin
        nerr++;
        $display("FAIL rr_grant%0d got g=%b v=%b a=%h exp g=%b v=1",
                 i, a_grant, a_s_valid, a_s_addr, exp_g[i]);
      end
      s_ready_a = 1;
      step();
      s_ready_a = 0;
      nvec++;
      if ({a_m1_ready, a_m0_ready} !== exp_g[i]) begin
        nerr++;
        $display("FAIL rr_ready%0d got %b exp %b",
                 i, {a_m1_ready, a_m0_ready}, exp_g[i]);
      end
      step();
      nvec++;
      if (a_grant !== 2'b00) begin
        nerr++;
        $display("FAIL rr_idle%0d got %b exp 00", i, a_grant);
      end
    end
    m0_valid = 0; m1_valid = 0;
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    m0_valid = 1; m1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (b_grant !== exp_g[i]) begin
        nerr++;
        $display("FAIL fp_grant%0d got %b exp %b", i, b_grant, exp_g[i]);
      end
      s_ready_b = 1;
      step();
      s_ready_b = 0;
      if (i == 2) m0_valid = 0;
      step();
    end
    m0_valid = 0; m1_valid = 0;
  endtask

  task automatic test_write_stall();
    logic [64:0] exp_v;
    do_reset();
    m1_valid = 1; m1_wstrb = 4'b0011;
    m1_wdata = 32'hAABBCCDD; m1_addr = 24'h000204;
    exp_v = {1'b1, 24'h000204, 4'b0011, 32'hAABBCCDD, 2'b10, 2'b00};
    step();
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if ({a_s_valid, a_s_addr, a_s_wstrb, a_s_wdata, a_grant,
           a_m1_ready, a_m0_ready} !== exp_v) begin
        nerr++;
        $display("FAIL wr_stall%0d got %h exp %h", i,
                 {a_s_valid, a_s_addr, a_s_wstrb, a_s_wdata, a_grant,
                  a_m1_ready, a_m0_ready}, exp_v);
      end
      if (i == 2) begin
        m1_addr = 24'hFFFFFF; m1_wdata = 32'h0; m1_wstrb = 4'hF;
      end
      step();
    end
    s_ready_a = 1; s_rdata = 32'h0;
    step();
    s_ready_a = 0; m1_valid = 0;
    nvec++;
    if ({a_m1_ready, a_m0_ready, a_err} !== 3'b100) begin
      nerr++;
      $display("FAIL wr_resp got %b exp 100", {a_m1_ready, a_m0_ready, a_err});
    end
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_valid = 1; m0_addr = 24'h000040; m0_wstrb = 0;
    step();
    for (int i = 1; i <= 8; i++) begin
      nvec++;
      if ({b_s_valid, b_m0_ready, b_err} !== 3'b100) begin
        nerr++;
        $display("FAIL to_wait%0d got %b exp 100",
                 i, {b_s_valid, b_m0_ready, b_err});
      end
      step();
    end
    nvec++;
    if ({b_s_valid, b_m0_ready, b_err} !== 3'b011 ||
        b_m0_rdata !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL to_resp got v=%b r=%b e=%b d=%h exp 0 1 1 deadbeef",
               b_s_valid, b_m0_ready, b_err, b_m0_rdata);
    end
    m0_valid = 0;
    step();
    m1_valid = 1; m1_addr = 24'h000080; m1_wstrb = 0;
    step();
    s_ready_b = 1; s_rdata = 32'h55AA55AA;
    step();
    s_ready_b = 0; m1_valid = 0;
    nvec++;
    if ({b_m1_ready, b_err} !== 2'b11 || b_m1_rdata !== 32'h55AA55AA ||
        b_m0_rdata !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL to_sticky got r=%b e=%b d1=%h d0=%h exp 1 1 55aa55aa deadbeef",
               b_m1_ready, b_err, b_m1_rdata, b_m0_rdata);
    end
    step();
    nvec++;
    if (b_err !== 1'b1) begin
      nerr++;
      $display("FAIL to_sticky2 got %b exp 1", b_err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    m0_valid = 1; m0_addr = 24'h000300;
    n = 0;
    while (a_err !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    nvec++;
    if (a_err !== 1'b1) begin
      nerr++;
      $display("FAIL rm_err_set got %b exp 1 (no timeout in 40 cycles)", a_err);
    end
    step(); step(); step();
    nvec++;
    if ({a_s_valid, a_grant} !== 3'b1_01) begin
      nerr++;
      $display("FAIL rm_busy got %b exp 101", {a_s_valid, a_grant});
    end
    reset = 1;
    step();
    reset = 0;
    nvec++;
    if ({a_s_valid, a_grant, a_m0_ready, a_m1_ready, a_err} !== 6'b0) begin
      nerr++;
      $display("FAIL rm_after got %b exp 000000",
               {a_s_valid, a_grant, a_m0_ready, a_m1_ready, a_err});
    end
    m1_valid = 1;
    step();
    nvec++;
    if (a_grant !== 2'b01) begin
      nerr++;
      $display("FAIL rm_tie got %b exp 01", a_grant);
    end
    s_ready_a = 1;
    step();
    s_ready_a = 0; m0_valid = 0; m1_valid = 0;
    step(); step();
  endtask

  task automatic test_drop_valid();
    int pulses;
    do_reset();
    m0_valid = 1; m0_addr = 24'h000500;
    step();
    m0_valid = 0;
    step(); step();
    nvec++;
    if ({a_s_valid, a_grant} !== 3'b1_01) begin
      nerr++;
      $display("FAIL dv_busy got %b exp 101", {a_s_valid, a_grant});
    end
    s_ready_a = 1; s_rdata = 32'h0BADF00D;
    step();
    s_ready_a = 0;
    pulses = 0;
    nvec++;
    if (a_m0_ready !== 1'b1 || a_m0_rdata !== 32'h0BADF00D) begin
      nerr++;
      $display("FAIL dv_resp got r=%b d=%h exp 1 0badf00d",
               a_m0_ready, a_m0_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_m0_ready === 1'b1) pulses++;
    end
    nvec++;
    if (pulses !== 0 || {a_s_valid, a_grant} !== 3'b0) begin
      nerr++;
      $display("FAIL dv_once got extra=%0d v/g=%b exp 0 000",
               pulses, {a_s_valid, a_grant});
    end
    s_ready_a = 1;
    step();
    s_ready_a = 0;
    nvec++;
    if ({a_s_valid, a_m0_ready, a_m1_ready} !== 3'b0 ||
        a_m0_rdata !== 32'h0BADF00D) begin
      nerr++;
      $display("FAIL dv_stray_ready got %b d=%h exp 000 0badf00d",
               {a_s_valid, a_m0_ready, a_m1_ready}, a_m0_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_fixed_prio();
    test_write_stall();
    test_timeout();
    test_reset_mid();
    test_drop_valid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
